// File: rtl/trigonometry_deg_sync_if.sv
// Angle-in / sine-cosine-out bundle for the integer-degree trig pipeline.
// The master drives the angle; the slave (generator) returns Q10 sine and cosine.
interface trigonometry_deg_sync_if;
    logic signed [31:0] i_theta;
    logic signed [31:0] o_cos;
    logic signed [31:0] o_sin;

    modport master (output i_theta, input o_cos, input o_sin);
    modport slave  (input i_theta, output o_cos, output o_sin);
endinterface

// File: rtl/trigonometry_deg_sync.sv
// Two-stage pipelined sine/cosine of an integer-degree angle, Q10 (1.0 = 1024).
// Stage 1 reduces the angle to quadrant/residual, stage 2 maps a quarter-wave ROM.
module trigonometry_deg_sync (
    input logic                     i_clock,
    input logic                     i_RESET,
    trigonometry_deg_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // round(1024 * sin(k deg)) for k = 0..90
    function automatic logic [10:0] quarter_sine(input logic [6:0] k);
        logic [10:0] t;
        t = '0;
        case (k)
            7'd0:  t = 11'd0;
            7'd1:  t = 11'd18;
            7'd2:  t = 11'd36;
            7'd3:  t = 11'd54;
            7'd4:  t = 11'd71;
            7'd5:  t = 11'd89;
            7'd6:  t = 11'd107;
            7'd7:  t = 11'd125;
            7'd8:  t = 11'd143;
            7'd9:  t = 11'd160;
            7'd10: t = 11'd178;
            7'd11: t = 11'd195;
            7'd12: t = 11'd213;
            7'd13: t = 11'd230;
            7'd14: t = 11'd248;
            7'd15: t = 11'd265;
            7'd16: t = 11'd282;
            7'd17: t = 11'd299;
            7'd18: t = 11'd316;
            7'd19: t = 11'd333;
            7'd20: t = 11'd350;
            7'd21: t = 11'd367;
            7'd22: t = 11'd384;
            7'd23: t = 11'd400;
            7'd24: t = 11'd416;
            7'd25: t = 11'd433;
            7'd26: t = 11'd449;
            7'd27: t = 11'd465;
            7'd28: t = 11'd481;
            7'd29: t = 11'd496;
            7'd30: t = 11'd512;
            7'd31: t = 11'd527;
            7'd32: t = 11'd543;
            7'd33: t = 11'd558;
            7'd34: t = 11'd573;
            7'd35: t = 11'd587;
            7'd36: t = 11'd602;
            7'd37: t = 11'd616;
            7'd38: t = 11'd630;
            7'd39: t = 11'd644;
            7'd40: t = 11'd658;
            7'd41: t = 11'd672;
            7'd42: t = 11'd685;
            7'd43: t = 11'd698;
            7'd44: t = 11'd711;
            7'd45: t = 11'd724;
            7'd46: t = 11'd737;
            7'd47: t = 11'd749;
            7'd48: t = 11'd761;
            7'd49: t = 11'd773;
            7'd50: t = 11'd784;
            7'd51: t = 11'd796;
            7'd52: t = 11'd807;
            7'd53: t = 11'd818;
            7'd54: t = 11'd828;
            7'd55: t = 11'd839;
            7'd56: t = 11'd849;
            7'd57: t = 11'd859;
            7'd58: t = 11'd868;
            7'd59: t = 11'd878;
            7'd60: t = 11'd887;
            7'd61: t = 11'd896;
            7'd62: t = 11'd904;
            7'd63: t = 11'd912;
            7'd64: t = 11'd920;
            7'd65: t = 11'd928;
            7'd66: t = 11'd935;
            7'd67: t = 11'd943;
            7'd68: t = 11'd949;
            7'd69: t = 11'd956;
            7'd70: t = 11'd962;
            7'd71: t = 11'd968;
            7'd72: t = 11'd974;
            7'd73: t = 11'd979;
            7'd74: t = 11'd984;
            7'd75: t = 11'd989;
            7'd76: t = 11'd994;
            7'd77: t = 11'd998;
            7'd78: t = 11'd1002;
            7'd79: t = 11'd1005;
            7'd80: t = 11'd1008;
            7'd81: t = 11'd1011;
            7'd82: t = 11'd1014;
            7'd83: t = 11'd1016;
            7'd84: t = 11'd1018;
            7'd85: t = 11'd1020;
            7'd86: t = 11'd1022;
            7'd87: t = 11'd1023;
            7'd88: t = 11'd1023;
            7'd89: t = 11'd1024;
            7'd90: t = 11'd1024;
            default: t = '0;
        endcase
        return t;
    endfunction

    // Negation on a 12-bit two's complement value keeps 0 as exactly 0
    function automatic logic signed [31:0] signed_out(input logic [10:0] t, input logic neg);
        logic signed [11:0] v;
        v = signed'({1'b0, t});
        if (neg) begin
            v = -v;
        end
        return 32'(v);
    endfunction

    logic signed [31:0] trunc_rem;
    logic [8:0]         mod_deg;
    quadrant_t          quad_d;
    logic [6:0]         resid_d;
    quadrant_t          quad_q;
    logic [6:0]         resid_q;
    logic [10:0]        t_resid;
    logic [10:0]        t_compl;
    logic signed [31:0] sin_next;
    logic signed [31:0] cos_next;

    // Truncating remainder follows the dividend's sign; fold negatives up by 360
    always_comb begin
        trunc_rem = bus.i_theta % 32'sd360;
        mod_deg   = 9'(trunc_rem[31] ? trunc_rem + 32'sd360 : trunc_rem);
    end

    always_comb begin
        quad_d  = QUAD_0;
        resid_d = 7'(mod_deg);
        if (mod_deg >= 9'd270) begin
            quad_d  = QUAD_3;
            resid_d = 7'(mod_deg - 9'd270);
        end else if (mod_deg >= 9'd180) begin
            quad_d  = QUAD_2;
            resid_d = 7'(mod_deg - 9'd180);
        end else if (mod_deg >= 9'd90) begin
            quad_d  = QUAD_1;
            resid_d = 7'(mod_deg - 9'd90);
        end
    end

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            quad_q  <= QUAD_0;
            resid_q <= '0;
        end else begin
            quad_q  <= quad_d;
            resid_q <= resid_d;
        end
    end

    always_comb begin
        t_resid  = quarter_sine(resid_q);
        t_compl  = quarter_sine(7'd90 - resid_q);
        sin_next = '0;
        cos_next = '0;
        case (quad_q)
            QUAD_0: begin
                sin_next = signed_out(t_resid, 1'b0);
                cos_next = signed_out(t_compl, 1'b0);
            end
            QUAD_1: begin
                sin_next = signed_out(t_compl, 1'b0);
                cos_next = signed_out(t_resid, 1'b1);
            end
            QUAD_2: begin
                sin_next = signed_out(t_resid, 1'b1);
                cos_next = signed_out(t_compl, 1'b1);
            end
            QUAD_3: begin
                sin_next = signed_out(t_compl, 1'b1);
                cos_next = signed_out(t_resid, 1'b0);
            end
            default: begin
                sin_next = '0;
                cos_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            bus.o_sin <= '0;
            bus.o_cos <= 32'sd1024;
        end else begin
            bus.o_sin <= sin_next;
            bus.o_cos <= cos_next;
        end
    end

endmodule

// File: tb/tb_trigonometry_deg_sync.sv
// Directed and sweep bench for trigonometry_deg_sync with a due-cycle scoreboard.
module tb_trigonometry_deg_sync;

    typedef struct {
        string tag;
        int    theta;
        int    exp_sin;
        int    exp_cos;
        int    due;
        bit    chk_pow;
    } exp_t;

    typedef struct {
        int th;
        int s;
        int c;
    } vec_t;

    logic i_clock = 1'b0;
    logic i_RESET = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    trigonometry_deg_sync_if bus ();

    trigonometry_deg_sync dut (
        .i_clock (i_clock),
        .i_RESET (i_RESET),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;
    always @(posedge i_clock) cyc <= cyc + 1;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int ref_sin(input int th);
        return rnd(1024.0 * $sin(real'(th) * 3.14159265358979323846 / 180.0));
    endfunction

    function automatic int ref_cos(input int th);
        return rnd(1024.0 * $cos(real'(th) * 3.14159265358979323846 / 180.0));
    endfunction

    task automatic put(input string tag, input int th, input int es, input int ec, input bit pw);
        exp_t e;
        bus.i_theta = th;
        e.tag = tag; e.theta = th; e.exp_sin = es; e.exp_cos = ec; e.due = cyc + 2; e.chk_pow = pw;
        sb.push_back(e);
    endtask

    task automatic drive(input string tag, input int th, input int es, input int ec, input bit pw);
        @(negedge i_clock);
        put(tag, th, es, ec, pw);
    endtask

    // Outputs change only on posedge, so the negedge is a stable sampling point
    always @(negedge i_clock) begin
        exp_t e;
        int   s;
        int   c;
        int   p;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            s = bus.o_sin;
            c = bus.o_cos;
            checks++;
            assert (e.due === cyc) else begin
                errors++;
                $error("FAIL %s align theta=%0d: observed due %0d expected %0d", e.tag, e.theta, cyc, e.due);
            end
            checks++;
            assert (bus.o_sin === e.exp_sin) else begin
                errors++;
                $error("FAIL %s sin theta=%0d: observed %0d expected %0d", e.tag, e.theta, s, e.exp_sin);
            end
            checks++;
            assert (bus.o_cos === e.exp_cos) else begin
                errors++;
                $error("FAIL %s cos theta=%0d: observed %0d expected %0d", e.tag, e.theta, c, e.exp_cos);
            end
            if (e.chk_pow) begin
                p = s * s + c * c;
                checks++;
                assert ((p >= 1048576 - 2048 && p <= 1048576 + 2048) === 1'b1) else begin
                    errors++;
                    $error("FAIL %s pow theta=%0d: observed %0d expected 1048576+-2048", e.tag, e.theta, p);
                end
            end
        end
    end

    initial begin
        vec_t dir[$];
        int   sweep_s;
        int   sweep_c;

        dir = '{
            '{0, 0, 1024}, '{90, 1024, 0}, '{180, 0, -1024}, '{270, -1024, 0},
            '{30, 512, 887}, '{45, 724, 724}, '{60, 887, 512},
            '{150, 512, -887}, '{225, -724, -724}, '{330, -512, 887},
            '{-90, -1024, 0}, '{-1, -18, 1024}, '{359, -18, 1024},
            '{360, 0, 1024}, '{361, 18, 1024}, '{720, 0, 1024}, '{450, 1024, 0},
            '{2147483647, 818, -616}, '{127, 818, -616},
            '{32'h8000_0000, -807, -630}, '{232, -807, -630}
        };

        bus.i_theta = 32'sd77;
        repeat (3) @(posedge i_clock);
        #1;
        checks++;
        assert (bus.o_cos === 32'sd1024) else begin
            errors++;
            $error("FAIL init_reset cos: observed %0d expected 1024", bus.o_cos);
        end
        checks++;
        assert (bus.o_sin === 32'sd0) else begin
            errors++;
            $error("FAIL init_reset sin: observed %0d expected 0", bus.o_sin);
        end

        @(negedge i_clock);
        i_RESET = 1'b0;

        foreach (dir[i]) drive("dir", dir[i].th, dir[i].s, dir[i].c, 1'b1);

        // Stream a few angles, then reset asynchronously between edges
        drive("pre_rst", 45, 724, 724, 1'b0);
        drive("pre_rst", 225, -724, -724, 1'b0);
        drive("pre_rst", 270, -1024, 0, 1'b0);
        @(posedge i_clock);
        #2;
        i_RESET = 1'b1;
        #1;
        sb.delete();
        checks++;
        assert (bus.o_cos === 32'sd1024) else begin
            errors++;
            $error("FAIL async_reset cos: observed %0d expected 1024", bus.o_cos);
        end
        checks++;
        assert (bus.o_sin === 32'sd0) else begin
            errors++;
            $error("FAIL async_reset sin: observed %0d expected 0", bus.o_sin);
        end
        @(negedge i_clock);
        @(negedge i_clock);
        i_RESET = 1'b0;
        begin
            exp_t h;
            h.tag = "post_rst_hold"; h.theta = 90; h.exp_sin = 0; h.exp_cos = 1024; h.due = cyc + 1; h.chk_pow = 1'b0;
            sb.push_back(h);
        end
        put("post_rst", 90, 1024, 0, 1'b0);

        for (int th = -720; th <= 720; th++) begin
            sweep_s = ref_sin(th);
            sweep_c = ref_cos(th);
            drive("sweep", th, sweep_s, sweep_c, 1'b1);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge i_clock);
            #1;
        end
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
